// File: rtl/usb_fx3_pkg.sv
// Shared FX3 slave-FIFO definitions for usb_stream_in / usb_stream_out.
// Contents: FSM state encodings (common 000..101 space), master_mode codes,
// socket addresses, bus widths and a counter-width helper.
package usb_fx3_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_CNT_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_WAIT_FA  = 3'b001,
    ST_WAIT_FB  = 3'b010,
    ST_WRITE    = 3'b011,
    ST_WRITE_WM = 3'b100,
    ST_PKTEND   = 3'b101
  } fx3_state_t;

  localparam logic [2:0] MODE_STREAM_IN  = 3'b010;
  localparam logic [2:0] MODE_STREAM_OUT = 3'b001;

  localparam logic [1:0] ADDR_SOCK_IN  = 2'd0;
  localparam logic [1:0] ADDR_SOCK_OUT = 2'd3;

  // Bits needed to hold values 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_stream_in_if.sv
// Fabric-side write stream (valid/ready handshake) into usb_stream_in.
// Signals: in_data (word), in_valid, in_last (final word of packet), in_ready.
// Modports: master = fabric producer, slave = usb_stream_in.
interface usb_stream_in_if;
  import usb_fx3_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);

endinterface

// File: rtl/usb_wm_budget.sv
// Watermark budget counter: load, decrement per accepted word, zero detect.
// Ports: clk, rst (sync, active-high), load, load_val, dec, zero_c (budget == 0).
module usb_wm_budget #(
  parameter int unsigned cnt_w = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [cnt_w-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [cnt_w-1:0] budget;

  // Load has priority; never decrement below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      budget <= '0;
    end else if (load) begin
      budget <= load_val;
    end else if (dec && !zero_c) begin
      budget <= budget - cnt_w'(1);
    end
  end

  assign zero_c = (budget == '0);

endmodule

// File: rtl/usb_stream_in.sv
// FPGA->host leg of the FX3 slave-FIFO link: takes fabric words on a
// valid/ready stream and writes them into socket 0 with SLWR/DQ, pacing on
// FLAGA (thread not full) / FLAGB (space above watermark), committing
// packets with PKTEND.
// Ports: clk, rst (sync, active-high), master_mode (3'b010 enables),
//   fab (usb_stream_in_if.slave: in_data/in_valid/in_last/in_ready),
//   FLAGA, FLAGB in; DQ, DQ_oe, PKTEND, SLOE, SLRD, SLCS, SLWR, A,
//   current_stream_in_mode (FSM state) out. FX3 outputs are registered;
//   in_ready is decoded from registered state.
// Build option: define USB_STREAM_IN_PKTEND_TIMEOUT_EN to commit a partial
//   packet after pktend_timeout idle cycles in WRITE.
module usb_stream_in
  import usb_fx3_pkg::*;
#(
  parameter int unsigned write_watermark = 4
`ifdef USB_STREAM_IN_PKTEND_TIMEOUT_EN
  , parameter int unsigned pktend_timeout = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        master_mode,
  usb_stream_in_if.slave    fab,
  input  logic              FLAGA,
  input  logic              FLAGB,
  output logic [DATA_W-1:0] DQ,
  output logic              DQ_oe,
  output logic              PKTEND,
  output logic              SLOE,
  output logic              SLRD,
  output logic              SLCS,
  output logic              SLWR,
  output logic [1:0]        A,
  output logic [2:0]        current_stream_in_mode
);

  localparam int unsigned BUDGET_W = cnt_width(write_watermark);

  fx3_state_t state, next_state;
  logic       mode_ok;
  logic       ready_c;
  logic       accept;
  logic       budget_zero;
  logic       budget_load;
  logic       budget_dec;
  logic       timeout_c;

  assign mode_ok      = (master_mode == MODE_STREAM_IN);
  assign fab.in_ready = ready_c;
  assign accept       = fab.in_valid && ready_c;

  usb_wm_budget #(.cnt_w(BUDGET_W)) u_budget (
    .clk      (clk),
    .rst      (rst),
    .load     (budget_load),
    .load_val (BUDGET_W'(write_watermark - 1)),
    .dec      (budget_dec),
    .zero_c   (budget_zero)
  );

`ifdef USB_STREAM_IN_PKTEND_TIMEOUT_EN
  localparam int unsigned IDLE_W = cnt_width(pktend_timeout);

  logic [IDLE_W-1:0]     idle_cnt;
  logic [WORD_CNT_W-1:0] word_cnt;

  // Words since the last commit; wraps silently.
  always_ff @(posedge clk) begin
    if (rst || state == ST_PKTEND) begin
      word_cnt <= '0;
    end else if (accept) begin
      word_cnt <= word_cnt + WORD_CNT_W'(1);
    end
  end

  // Consecutive no-accept cycles in WRITE while a partial packet is open.
  always_ff @(posedge clk) begin
    if (rst || state != ST_WRITE || accept) begin
      idle_cnt <= '0;
    end else if (word_cnt != '0) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  assign timeout_c = (state == ST_WRITE) && !accept && (word_cnt != '0) &&
                     (idle_cnt == IDLE_W'(pktend_timeout - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Ready decode from registered state and budget.
  always_comb begin
    ready_c = 1'b0;
    case (state)
      ST_WRITE:    ready_c = 1'b1;
      ST_WRITE_WM: ready_c = !budget_zero;
      default:     ready_c = 1'b0;
    endcase
  end

  // Next state. A word accepted with in_last wins over FLAGA/FLAGB/budget;
  // a mode change parks the block without committing.
  always_comb begin
    next_state  = state;
    budget_load = 1'b0;
    budget_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode_ok) next_state = ST_WAIT_FA;
      end
      ST_WAIT_FA: begin
        if (!mode_ok)   next_state = ST_IDLE;
        else if (FLAGA) next_state = ST_WAIT_FB;
      end
      ST_WAIT_FB: begin
        if (!mode_ok)   next_state = ST_IDLE;
        else if (FLAGB) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        if (!mode_ok) begin
          next_state = ST_IDLE;
        end else if (accept && fab.in_last) begin
          next_state = ST_PKTEND;
        end else if (!FLAGA) begin
          next_state = ST_WAIT_FA;
        end else if (!FLAGB) begin
          // A word accepted this cycle belongs to the full burst.
          next_state  = ST_WRITE_WM;
          budget_load = 1'b1;
        end else if (timeout_c) begin
          next_state = ST_PKTEND;
        end
      end
      ST_WRITE_WM: begin
        budget_dec = accept;
        if (!mode_ok) begin
          next_state = ST_IDLE;
        end else if (accept && fab.in_last) begin
          next_state = ST_PKTEND;
        end else if (!FLAGA || budget_zero) begin
          next_state = ST_WAIT_FA;
        end
      end
      ST_PKTEND: begin
        next_state = mode_ok ? ST_WAIT_FA : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FX3 pin registers. PKTEND follows the PKTEND state by one cycle so the
  // final SLWR pulse always precedes it. DQ_oe is held for a last pulse that
  // completes on the way into IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      SLWR   <= 1'b1;
      PKTEND <= 1'b1;
      SLOE   <= 1'b1;
      SLRD   <= 1'b1;
      SLCS   <= 1'b0;
      A      <= ADDR_SOCK_IN;
      DQ     <= '0;
      DQ_oe  <= 1'b0;
    end else begin
      SLWR   <= !accept;
      PKTEND <= (state != ST_PKTEND);
      SLOE   <= 1'b1;
      SLRD   <= 1'b1;
      SLCS   <= 1'b0;
      A      <= ADDR_SOCK_IN;
      if (accept) DQ <= fab.in_data;
      DQ_oe  <= (next_state != ST_IDLE) || accept;
    end
  end

  assign current_stream_in_mode = state;

endmodule

// File: tb/tb_usb_stream_in.sv
// Directed, table-driven bench for usb_stream_in (write_watermark = 4).
// Each table row gives one cycle of inputs and the outputs expected right
// after the edge that consumes them; hand sequences cover the idle/timeout
// corner. Honours USB_STREAM_IN_PKTEND_TIMEOUT_EN (timeout 8).
module tb_usb_stream_in;

  typedef struct {
    logic        rst;
    logic [2:0]  mode;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        fa;
    logic        fb;
    logic [2:0]  st;
    logic        rdy;
    logic        slwr;
    logic [31:0] dq;
    logic        pk;
    logic        oe;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic        fa, fb;
  logic [31:0] dq;
  logic        dq_oe, pktend, sloe, slrd, slcs, slwr;
  logic [1:0]  a;
  logic [2:0]  st;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  usb_stream_in_if fab_if ();

  usb_stream_in #(
    .write_watermark (4)
`ifdef USB_STREAM_IN_PKTEND_TIMEOUT_EN
    , .pktend_timeout (8)
`endif
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .master_mode            (mode),
    .fab                    (fab_if.slave),
    .FLAGA                  (fa),
    .FLAGB                  (fb),
    .DQ                     (dq),
    .DQ_oe                  (dq_oe),
    .PKTEND                 (pktend),
    .SLOE                   (sloe),
    .SLRD                   (slrd),
    .SLCS                   (slcs),
    .SLWR                   (slwr),
    .A                      (a),
    .current_stream_in_mode (st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [2:0] m, input logic v, input logic [31:0] d,
                     input logic l, input logic fla, input logic flb, input logic [2:0] es,
                     input logic er, input logic ew, input logic [31:0] ed, input logic ep,
                     input logic eo);
    vec_t x;
    x.rst = r; x.mode = m; x.valid = v; x.data = d; x.last = l; x.fa = fla; x.fb = flb;
    x.st = es; x.rdy = er; x.slwr = ew; x.dq = ed; x.pk = ep; x.oe = eo;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic r, input logic [2:0] m, input logic v, input logic [31:0] d,
                       input logic l, input logic fla, input logic flb);
    rst = r; mode = m; fab_if.in_valid = v; fab_if.in_data = d; fab_if.in_last = l;
    fa = fla; fb = flb;
  endtask

  localparam logic [2:0] M = 3'b010;
  localparam logic [2:0] O = 3'b001;

  initial begin
    int lows;
    bit got;
    drive(1'b1, M, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // 1: three back-to-back words, last commits
    add(0,M,0,0,0,1,1, 3'd1,0,1,0,1,1);
    add(0,M,0,0,0,1,1, 3'd2,0,1,0,1,1);
    add(0,M,0,0,0,1,1, 3'd3,1,1,0,1,1);
    add(0,M,1,32'h11,0,1,1, 3'd3,1,0,32'h11,1,1);
    add(0,M,1,32'h22,0,1,1, 3'd3,1,0,32'h22,1,1);
    add(0,M,1,32'h33,1,1,1, 3'd5,0,0,32'h33,1,1);
    add(0,M,0,0,0,1,1, 3'd1,0,1,32'h33,0,1);
    add(0,M,0,0,0,1,1, 3'd2,0,1,32'h33,1,1);
    add(0,M,0,0,0,1,1, 3'd3,1,1,32'h33,1,1);
    // 2: FLAGB falls with word 2 -> 3 more words, then re-arm
    add(0,M,1,32'hA1,0,1,1, 3'd3,1,0,32'hA1,1,1);
    add(0,M,1,32'hA2,0,1,0, 3'd4,1,0,32'hA2,1,1);
    add(0,M,1,32'hA3,0,1,0, 3'd4,1,0,32'hA3,1,1);
    add(0,M,1,32'hA4,0,1,0, 3'd4,1,0,32'hA4,1,1);
    add(0,M,1,32'hA5,0,1,0, 3'd4,0,0,32'hA5,1,1);
    add(0,M,1,32'hA6,0,1,0, 3'd1,0,1,32'hA5,1,1);
    add(0,M,1,32'hA6,0,1,0, 3'd2,0,1,32'hA5,1,1);
    add(0,M,1,32'hA6,0,1,1, 3'd3,1,1,32'hA5,1,1);
    add(0,M,1,32'hA6,0,1,1, 3'd3,1,0,32'hA6,1,1);
    add(0,M,1,32'hA7,0,1,1, 3'd3,1,0,32'hA7,1,1);
    add(0,M,1,32'hA8,0,1,1, 3'd3,1,0,32'hA8,1,1);
    add(0,M,1,32'hA9,1,1,1, 3'd5,0,0,32'hA9,1,1);
    add(0,M,0,0,0,1,1, 3'd1,0,1,32'hA9,0,1);
    add(0,M,0,0,0,1,1, 3'd2,0,1,32'hA9,1,1);
    add(0,M,0,0,0,1,1, 3'd3,1,1,32'hA9,1,1);
    // 3: reset, FLAGA low holds WAIT_FA
    add(1,M,0,0,0,1,1, 3'd0,0,1,0,1,0);
    add(0,M,0,0,0,0,0, 3'd1,0,1,0,1,1);
    add(0,M,0,0,0,0,0, 3'd1,0,1,0,1,1);
    add(0,M,0,0,0,0,0, 3'd1,0,1,0,1,1);
    add(0,M,0,0,0,1,0, 3'd2,0,1,0,1,1);
    add(0,M,0,0,0,1,1, 3'd3,1,1,0,1,1);
    // 4: mode leaves after 0xAB accepted
    add(0,M,1,32'hAB,0,1,1, 3'd3,1,0,32'hAB,1,1);
    add(0,O,0,0,0,1,1, 3'd0,0,1,32'hAB,1,0);
    add(0,O,0,0,0,1,1, 3'd0,0,1,32'hAB,1,0);
    // 5: reset during WRITE_WM drops the pending word
    add(0,M,0,0,0,1,1, 3'd1,0,1,32'hAB,1,1);
    add(0,M,0,0,0,1,1, 3'd2,0,1,32'hAB,1,1);
    add(0,M,0,0,0,1,1, 3'd3,1,1,32'hAB,1,1);
    add(0,M,1,32'hB1,0,1,0, 3'd4,1,0,32'hB1,1,1);
    add(1,M,1,32'hB2,0,1,0, 3'd0,0,1,0,1,0);
    add(0,M,0,0,0,1,1, 3'd1,0,1,0,1,1);
    // FLAGA drop while writing: accepted word still written
    add(0,M,0,0,0,1,1, 3'd2,0,1,0,1,1);
    add(0,M,0,0,0,1,1, 3'd3,1,1,0,1,1);
    add(0,M,1,32'hC1,0,0,1, 3'd1,0,0,32'hC1,1,1);
    add(0,M,0,0,0,1,1, 3'd2,0,1,32'hC1,1,1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 32'(st), 32'd0);
    chk("rst.ready", 32'(fab_if.in_ready), 32'd0);
    chk("rst.slwr", 32'(slwr), 32'd1);
    chk("rst.pktend", 32'(pktend), 32'd1);
    chk("rst.sloe_slrd", 32'({sloe, slrd}), 32'd3);
    chk("rst.slcs", 32'(slcs), 32'd0);
    chk("rst.a", 32'(a), 32'd0);
    chk("rst.dq", dq, 32'd0);
    chk("rst.dq_oe", 32'(dq_oe), 32'd0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.mode, v.valid, v.data, v.last, v.fa, v.fb);
      step();
      chk($sformatf("v%0d.state", i), 32'(st), 32'(v.st));
      chk($sformatf("v%0d.ready", i), 32'(fab_if.in_ready), 32'(v.rdy));
      chk($sformatf("v%0d.slwr", i), 32'(slwr), 32'(v.slwr));
      chk($sformatf("v%0d.dq", i), dq, v.dq);
      chk($sformatf("v%0d.pktend", i), 32'(pktend), 32'(v.pk));
      chk($sformatf("v%0d.dq_oe", i), 32'(dq_oe), 32'(v.oe));
      chk($sformatf("v%0d.static", i), 32'({sloe, slrd, slcs, a}), 32'b11000);
    end

    // 6: partial packet then idle
    drive(0, M, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      step();
      got = fab_if.in_ready;
    end
    chk("t6.wait_ready", 32'(got), 32'd1);
    drive(0, M, 1'b1, 32'hD1, 1'b0, 1'b1, 1'b1);
    step();
    chk("t6.d1", dq, 32'hD1);
    drive(0, M, 1'b1, 32'hD2, 1'b0, 1'b1, 1'b1);
    step();
    chk("t6.d2", dq, 32'hD2);
    chk("t6.d2_slwr", 32'(slwr), 32'd0);
    drive(0, M, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("t6.idle%0d_pktend", k), 32'(pktend), 32'd1);
    end
    step();
`ifdef USB_STREAM_IN_PKTEND_TIMEOUT_EN
    chk("t6.idle9_pktend", 32'(pktend), 32'd0);
    chk("t6.idle9_state", 32'(st), 32'd1);
`else
    chk("t6.idle9_pktend", 32'(pktend), 32'd1);
    chk("t6.idle9_state", 32'(st), 32'd3);
`endif
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (pktend == 1'b0) lows++;
    end
    chk("t6.no_repeat_commit", 32'(lows), 32'd0);
    chk("t6.final_state", 32'(st), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
